// File: rtl/ex_wb_buffer.sv
// Execute-to-writeback result stage: selects the load or ALU result and queues it in a
// DEPTH-entry FIFO with valid/ready handshakes on both sides, flush and occupancy reporting.
module ex_wb_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned LD_BIT = 0,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [INST_W-1:0] ex_inst,
    input  logic [DATA_W-1:0] ex_ld_res,
    input  logic [DATA_W-1:0] ex_res,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_wbv,
    output logic              wb_is_ld,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Each entry holds {is_ld, value}.
    logic [DATA_W:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic              sel_ld;
    logic [DATA_W-1:0] ex_wbv;
    logic [DATA_W:0]   head;
    logic              full;
    logic              push;
    logic              pop;

    assign sel_ld = (ex_inst[LD_BIT] == 1'b0);
    assign ex_wbv = sel_ld ? ex_ld_res : ex_res;

    // ex_ready depends only on state and flush, never on wb_ready.
    assign full     = (count_q == FULL_CNT);
    assign ex_ready = !full && !flush;
    assign wb_valid = (count_q != '0);
    assign push     = ex_valid && ex_ready;
    assign pop      = wb_valid && wb_ready;

    assign head     = mem_q[rd_ptr_q];
    assign wb_wbv   = wb_valid ? head[DATA_W-1:0] : '0;
    assign wb_is_ld = wb_valid ? head[DATA_W] : 1'b0;
    assign count    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; output masking hides stale entries.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= {sel_ld, ex_wbv};
        end
    end

endmodule

// File: tb/tb_ex_wb_buffer.sv
// Bench for ex_wb_buffer: DEPTH=2 and DEPTH=3 instances share stimulus and are checked
// every cycle against queue models, plus directed literal expectations.
module tb_ex_wb_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, ex_valid, wb_ready;
    logic [31:0] ex_inst, ex_ld_res, ex_res;

    logic        d2_ex_ready, d2_wb_valid, d2_wb_is_ld;
    logic [31:0] d2_wb_wbv;
    logic [1:0]  d2_count;
    logic        d3_ex_ready, d3_wb_valid, d3_wb_is_ld;
    logic [31:0] d3_wb_wbv;
    logic [1:0]  d3_count;

    ex_wb_buffer #(.DATA_W(32), .INST_W(32), .LD_BIT(0), .DEPTH(2)) u_d2 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .ex_valid  (ex_valid),
        .ex_ready  (d2_ex_ready),
        .ex_inst   (ex_inst),
        .ex_ld_res (ex_ld_res),
        .ex_res    (ex_res),
        .wb_valid  (d2_wb_valid),
        .wb_ready  (wb_ready),
        .wb_wbv    (d2_wb_wbv),
        .wb_is_ld  (d2_wb_is_ld),
        .count     (d2_count)
    );

    ex_wb_buffer #(.DATA_W(32), .INST_W(32), .LD_BIT(0), .DEPTH(3)) u_d3 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .ex_valid  (ex_valid),
        .ex_ready  (d3_ex_ready),
        .ex_inst   (ex_inst),
        .ex_ld_res (ex_ld_res),
        .ex_res    (ex_res),
        .wb_valid  (d3_wb_valid),
        .wb_ready  (wb_ready),
        .wb_wbv    (d3_wb_wbv),
        .wb_is_ld  (d3_wb_is_ld),
        .count     (d3_count)
    );

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    // Model: one queue of {is_ld, value} per instance.
    logic [32:0] mq [2][$];
    int          mdepth [2] = '{2, 3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit          do_push, do_pop;
            logic [32:0] entry;
            do_push = ex_valid && (mq[k].size() < mdepth[k]) && !flush;
            do_pop  = (mq[k].size() != 0) && wb_ready;
            entry   = (ex_inst[0] == 1'b0) ? {1'b1, ex_ld_res} : {1'b0, ex_res};
            if (rst || flush) begin
                mq[k].delete();
            end else begin
                if (do_pop) void'(mq[k].pop_front());
                if (do_push) mq[k].push_back(entry);
            end
        end
    end

    task automatic compare_one(input int k, input logic rdy, input logic vld,
                               input logic [31:0] wbv, input logic isld, input logic [1:0] cnt);
        int          n;
        logic [32:0] h;
        n = mq[k].size();
        h = (n != 0) ? mq[k][0] : 33'h0;
        check($sformatf("d%0d ex_ready", mdepth[k]), {31'b0, rdy},
              {31'b0, (n < mdepth[k]) && !flush});
        check($sformatf("d%0d wb_valid", mdepth[k]), {31'b0, vld}, {31'b0, n != 0});
        check($sformatf("d%0d wb_wbv", mdepth[k]), wbv, h[31:0]);
        check($sformatf("d%0d wb_is_ld", mdepth[k]), {31'b0, isld}, {31'b0, h[32]});
        check($sformatf("d%0d count", mdepth[k]), {30'b0, cnt}, n);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            compare_one(0, d2_ex_ready, d2_wb_valid, d2_wb_wbv, d2_wb_is_ld, d2_count);
            compare_one(1, d3_ex_ready, d3_wb_valid, d3_wb_wbv, d3_wb_is_ld, d3_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ld=1 selects the load path (ex_inst[0]=0); upper instruction bits are noise.
    task automatic drive(input logic v, input logic ld, input logic [31:0] lres,
                         input logic [31:0] ares);
        ex_valid  = v;
        ex_inst   = ld ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
        ex_ld_res = lres;
        ex_res    = ares;
    endtask

    task automatic drain();
        ex_valid = 1'b0;
        wb_ready = 1'b1;
        repeat (4) tick();
        wb_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        armed = 1'b1;
        check("reset wb_valid", {31'b0, d2_wb_valid}, 32'd0);
        check("reset ex_ready", {31'b0, d2_ex_ready}, 32'd1);
        check("reset wb_wbv", d2_wb_wbv, 32'h0);

        // Load path.
        drive(1'b1, 1'b1, 32'hA5A5_0001, 32'h1111_1111);
        tick();
        ex_valid = 1'b0;
        check("ld wb_valid", {31'b0, d2_wb_valid}, 32'd1);
        check("ld wb_wbv", d2_wb_wbv, 32'hA5A5_0001);
        check("ld wb_is_ld", {31'b0, d2_wb_is_ld}, 32'd1);
        check("ld count", {30'b0, d2_count}, 32'd1);
        drain();

        // ALU path, then a single-cycle pop.
        drive(1'b1, 1'b0, 32'hA5A5_0001, 32'h1111_1111);
        tick();
        ex_valid = 1'b0;
        check("alu wb_wbv", d2_wb_wbv, 32'h1111_1111);
        check("alu wb_is_ld", {31'b0, d2_wb_is_ld}, 32'd0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("pop wb_valid", {31'b0, d2_wb_valid}, 32'd0);
        check("pop wb_wbv", d2_wb_wbv, 32'h0);
        check("pop count", {30'b0, d2_count}, 32'd0);

        // Backpressure.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 32'hBAD0_0000, i);
            tick();
            if (i == 2) begin
                check("bp full ex_ready", {31'b0, d2_ex_ready}, 32'd0);
                check("bp full count", {30'b0, d2_count}, 32'd2);
            end
        end
        check("bp 3 blocked count", {30'b0, d2_count}, 32'd2);
        check("bp head 1", d2_wb_wbv, 32'd1);
        check("bp d3 count", {30'b0, d3_count}, 32'd3);
        wb_ready = 1'b1;
        tick();
        check("bp head 2", d2_wb_wbv, 32'd2);
        check("bp ready back", {31'b0, d2_ex_ready}, 32'd1);
        tick();
        check("bp head 3", d2_wb_wbv, 32'd3);
        check("bp count after 3", {30'b0, d2_count}, 32'd1);
        drain();

        // Streaming with simultaneous push and pop.
        drive(1'b1, 1'b0, 32'hBAD0_0000, 32'd0);
        tick();
        check("stream head 0", d3_wb_wbv, 32'd0);
        wb_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 1'b0, 32'hBAD0_0000, i);
            tick();
            check($sformatf("stream head %0d", i), d3_wb_wbv, i);
            check($sformatf("stream count %0d", i), {30'b0, d3_count}, 32'd1);
        end
        drain();

        // Flush with a concurrent push.
        drive(1'b1, 1'b0, 32'h0, 32'h10);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'h20);
        tick();
        check("pre-flush count", {30'b0, d2_count}, 32'd2);
        drive(1'b1, 1'b0, 32'h0, 32'hF1F1_F1F1);
        flush = 1'b1;
        #1;
        check("flush ex_ready", {31'b0, d3_ex_ready}, 32'd0);
        tick();
        flush = 1'b0;
        ex_valid = 1'b0;
        check("flush count", {30'b0, d2_count}, 32'd0);
        check("flush wb_valid", {31'b0, d3_wb_valid}, 32'd0);
        check("flush wb_wbv", d2_wb_wbv, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 32'h55);
        tick();
        ex_valid = 1'b0;
        check("post-flush head", d2_wb_wbv, 32'h55);
        check("post-flush count", {30'b0, d3_count}, 32'd1);
        drain();

        // Reset mid-stream with a concurrent push.
        drive(1'b1, 1'b1, 32'h30, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h40, 32'h0);
        tick();
        check("pre-rst count", {30'b0, d2_count}, 32'd2);
        drive(1'b1, 1'b1, 32'h99, 32'h0);
        rst = 1'b1;
        tick();
        check("rst wb_valid", {31'b0, d2_wb_valid}, 32'd0);
        check("rst wb_wbv", d2_wb_wbv, 32'h0);
        check("rst wb_is_ld", {31'b0, d2_wb_is_ld}, 32'd0);
        check("rst count", {30'b0, d3_count}, 32'd0);
        check("rst ex_ready", {31'b0, d2_ex_ready}, 32'd1);
        rst = 1'b0;
        ex_valid = 1'b0;
        wb_ready = 1'b1;
        tick();
        tick();
        check("post-rst wb_valid", {31'b0, d3_wb_valid}, 32'd0);
        wb_ready = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_wb_buffer.md
Name: ex_wb_buffer

Overview:
Parametrised execute-to-writeback result stage. Each cycle it selects between the load result and the ALU result using one instruction bit, and the earlier design only registered that selection. This block instead queues the selected value in a DEPTH-entry FIFO with valid/ready handshakes on both sides, which decouples a stalling writeback stage from execute. It adds pipeline flush and occupancy reporting, and masks the data outputs while nothing is valid.

Parameters:
DATA_W, 32, width of ex_ld_res, ex_res, wb_wbv
INST_W, 32, width of ex_inst
LD_BIT, 0, index of the ex_inst bit that selects the source; must be < INST_W
DEPTH, 2, number of FIFO entries; must be >= 1; need not be a power of two
CNT_W, $clog2(DEPTH+1), width of the occupancy output

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  synchronous pipeline flush; discards all queued entries
ex_valid  input  1  execute stage presents a result this cycle
ex_ready  output  1  buffer accepts the result this cycle
ex_inst  input  INST_W  instruction in execute
ex_ld_res  input  DATA_W  load-path result
ex_res  input  DATA_W  ALU-path result
wb_valid  output  1  head entry is valid
wb_ready  input  1  writeback consumes the head this cycle
wb_wbv  output  DATA_W  writeback value of the head entry
wb_is_ld  output  1  head entry came from the load path
count  output  CNT_W  number of queued entries

Behaviour:
- Source select (combinational, execute side):
  - sel_ld = (ex_inst[LD_BIT] == 0).
  - ex_wbv = sel_ld ? ex_ld_res : ex_res.
  - Stored entry = {sel_ld, ex_wbv}.
- Push = ex_valid && ex_ready. Pop = wb_valid && wb_ready.
- ex_ready = !full && !flush, where full = (count == DEPTH).
  - No combinational path from wb_ready to ex_ready.
  - When full, a same-cycle pop does not enable a push.
- wb_valid = (count != 0). Both outputs come straight from state, so an accepted entry appears at the output the next cycle.
- Data masking:
  - wb_wbv = head data and wb_is_ld = head flag when wb_valid = 1.
  - Both are forced to 0 when wb_valid = 0, so stale data never appears at the output.
- Latency: a push at edge t gives wb_valid = 1 with that value after edge t. Queued entries leave in push order.
- Pointers:
  - wr_ptr and rd_ptr each advance by 1 on push and pop respectively.
  - They wrap from DEPTH-1 to 0, with an explicit compare (not a power-of-two mask).
- count update:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop, which is legal whenever 0 < count < DEPTH.
- Empty: no pop can occur; wb_ready is ignored.
- Full: push is blocked and a pop proceeds normally.
- Flush (synchronous):
  - At the edge: count = 0 and wr_ptr = rd_ptr = 0.
  - The same-cycle push is dropped (ex_ready is already 0).
  - A same-cycle pop is irrelevant.
  - Storage contents need not be cleared; masking hides them.
- Reset:
  - rst has priority over flush and all handshakes.
  - At the edge: count = 0, both pointers 0, wb_valid = 0, wb_wbv = 0, wb_is_ld = 0.
  - ex_ready = 1 after the edge unless flush is asserted.
  - A reset mid-stream discards all queued entries.
- ex_inst, ex_ld_res and ex_res are ignored when ex_valid = 0.

Test Plan:
- Reset then single push with DATA_W = 32: apply ex_inst[0] = 0, ex_ld_res = 0xA5A5_0001, ex_res = 0x1111_1111, ex_valid = 1. Required: after the next edge, wb_valid = 1, wb_wbv = 0xA5A5_0001, wb_is_ld = 1, count = 1.
- ALU path: same as above but ex_inst[0] = 1. Required: wb_wbv = 0x1111_1111, wb_is_ld = 0. Then pulse wb_ready for one cycle. Required: wb_valid = 0, wb_wbv = 0, count = 0.
- Backpressure, DEPTH = 2: hold wb_ready = 0 and push 3 values 1, 2, 3 back-to-back. Required: ex_ready = 0 after the 2nd push and count = 2; value 3 is not accepted while ex_ready = 0. Then raise wb_ready. Required: outputs 1 then 2, and 3 is accepted once ex_ready returns to 1.
- Streaming, DEPTH = 3: push and pop simultaneously every cycle for 10 cycles with values 0..9. Required: count stays 1, output order is 0..9, and wrap-around past index 2 shows no gap.
- Flush with count = 2 and ex_valid = 1 in the same cycle. Required: after the edge, count = 0, wb_valid = 0, wb_wbv = 0, and the flushed-cycle value never appears. The next push appears normally.
- Reset mid-operation with count = 2 and rst = 1 together with flush = 0 and ex_valid = 1. Required: all outputs are 0 after the edge, ex_ready = 1, and none of the old entries is ever output.
